// File: rtl/cache_nway.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU and dirty flush walker.
// Latency: hit returns the cycle after request; miss = memory latency + 2 (+ writeback when the victim is dirty).
// Backpressure: mem_*_req held until matching ack; the requester holds master_enable until hit.
module cache_nway #(
  parameter int    WIDTH = 128,
  parameter int    DEPTH = 4,
  parameter int    WAYS  = 2,
  parameter string ALIAS = "Cache"
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic                 read_write,
  input  logic                 master_enable,
  input  logic [WIDTH/8-1:0]   byte_enable,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 flush,
  output logic [WIDTH-1:0]     data_out,
  output logic                 hit,
  output logic                 flush_done,
  output logic                 mem_write_req,
  output logic [31:0]          mem_write_addr,
  output logic [WIDTH-1:0]     mem_write_data,
  input  logic                 mem_write_ack,
  output logic                 mem_read_req,
  output logic [31:0]          mem_read_addr,
  input  logic [WIDTH-1:0]     mem_read_data,
  input  logic                 mem_read_ack
);
  localparam int BYTES = WIDTH / 8;
  localparam int WB    = $clog2(BYTES);
  localparam int DB    = $clog2(DEPTH);
  localparam int TW    = 32 - WB - DB;
  localparam int WAYB  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PB    = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [2:0] {IDLE, EVICT, FILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0] line_q  [DEPTH][WAYS];
  logic [TW-1:0]    tag_q   [DEPTH][WAYS];
  logic [WAYS-1:0]  valid_q [DEPTH];
  logic [WAYS-1:0]  dirty_q [DEPTH];
  logic [PB-1:0]    plru_q  [DEPTH];

  logic [DB-1:0]    idx, v_idx, fset;
  logic [TW-1:0]    tag, v_tag;
  logic [WAYB-1:0]  hit_way, vic_way, v_way, fway;
  logic [WAYS-1:0]  match;
  logic             any_hit, vic_dirty, f_vd, f_last;
  logic [WIDTH-1:0] hit_line, merged;
  logic             unused_offset;

  assign idx           = addr[WB+DB-1:WB];
  assign tag           = addr[31:WB+DB];
  assign unused_offset = ^addr[WB-1:0];

  // Node bit 0 = victim in left subtree, 1 = right; touching points every node on the path away.
  function automatic logic [PB-1:0] plru_touch(input logic [PB-1:0] cur, input logic [WAYB-1:0] w);
    logic [PB-1:0]   r;
    logic [WAYB-1:0] sh;
    int              n;
    r = cur;
    n = 0;
    for (int l = WAYB - 1; l >= 0; l--) begin
      sh = w >> l;
      if (sh[0]) r = r & ~(PB'(1) << n);
      else       r = r | (PB'(1) << n);
      n = 2 * n + 1 + int'(sh[0]);
    end
    return r;
  endfunction

  function automatic logic [WAYB-1:0] plru_victim(input logic [PB-1:0] cur);
    logic [PB-1:0] sh;
    int            n;
    if (WAYS == 1) return '0;
    n = 0;
    for (int l = 0; l < WAYB; l++) begin
      sh = cur >> n;
      n  = 2 * n + 1 + int'(sh[0]);
    end
    return WAYB'(n - (WAYS - 1));
  endfunction

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
      if (match[w]) hit_way = WAYB'(w);
    end
    any_hit = |match;
  end

  // Lowest invalid way wins over the PLRU choice.
  always_comb begin
    vic_way = plru_victim(plru_q[idx]);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) vic_way = WAYB'(w);
    vic_dirty = valid_q[idx][vic_way] && dirty_q[idx][vic_way];
  end

  always_comb begin
    hit_line = line_q[idx][hit_way];
    merged   = hit_line;
    for (int b = 0; b < BYTES; b++)
      if (byte_enable[b]) merged[8*b +: 8] = data_in[8*b +: 8];
  end

  assign f_vd   = valid_q[fset][fway] && dirty_q[fset][fway];
  assign f_last = (fset == DB'(DEPTH - 1)) && (fway == WAYB'(WAYS - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (flush)                          state_n = FLUSH_SCAN;
        else if (master_enable && !any_hit) state_n = vic_dirty ? EVICT : FILL;
      end
      EVICT:      if (mem_write_ack) state_n = FILL;
      FILL:       if (mem_read_ack)  state_n = IDLE;
      FLUSH_SCAN: begin
        if (f_vd)        state_n = FLUSH_WB;
        else if (f_last) state_n = FLUSH_DONE;
      end
      FLUSH_WB:   if (mem_write_ack) state_n = FLUSH_SCAN;
      FLUSH_DONE: state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit            <= 1'b0;
      data_out       <= '0;
      flush_done     <= 1'b0;
      mem_write_req  <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      mem_read_req   <= 1'b0;
      mem_read_addr  <= '0;
      v_idx          <= '0;
      v_way          <= '0;
      v_tag          <= '0;
      fset           <= '0;
      fway           <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        valid_q[d] <= '0;
        dirty_q[d] <= '0;
        plru_q[d]  <= '0;
      end
    end else begin
      hit        <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            fset <= '0;
            fway <= '0;
          end else if (master_enable) begin
            if (any_hit) begin
              hit         <= 1'b1;
              plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
              if (read_write) begin
                data_out <= hit_line;
              end else begin
                data_out                  <= merged;
                line_q[idx][hit_way]      <= merged;
                dirty_q[idx][hit_way]     <= 1'b1;
              end
            end else begin
              valid_q[idx][vic_way] <= 1'b0;
              v_idx                 <= idx;
              v_way                 <= vic_way;
              v_tag                 <= tag;
              mem_read_addr         <= {addr[31:WB], {WB{1'b0}}};
              if (vic_dirty) begin
                mem_write_req  <= 1'b1;
                mem_write_addr <= {tag_q[idx][vic_way], idx, {WB{1'b0}}};
                mem_write_data <= line_q[idx][vic_way];
              end else begin
                mem_read_req <= 1'b1;
              end
            end
          end
        end
        EVICT: if (mem_write_ack) begin
          mem_write_req <= 1'b0;
          mem_read_req  <= 1'b1;
        end
        FILL: if (mem_read_ack) begin
          line_q[v_idx][v_way]  <= mem_read_data;
          tag_q[v_idx][v_way]   <= v_tag;
          valid_q[v_idx][v_way] <= 1'b1;
          dirty_q[v_idx][v_way] <= 1'b0;
          mem_read_req          <= 1'b0;
        end
        FLUSH_SCAN: begin
          if (f_vd) begin
            mem_write_req  <= 1'b1;
            mem_write_addr <= {tag_q[fset][fway], fset, {WB{1'b0}}};
            mem_write_data <= line_q[fset][fway];
          end else if (fway == WAYB'(WAYS - 1)) begin
            fway <= '0;
            fset <= fset + 1'b1;
          end else begin
            fway <= fway + 1'b1;
          end
        end
        FLUSH_WB: if (mem_write_ack) begin
          mem_write_req       <= 1'b0;
          dirty_q[fset][fway] <= 1'b0;
        end
        FLUSH_DONE: flush_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset) (state == IDLE && master_enable) |-> $onehot0(match))
    else $error("%s: tag matched in more than one way", ALIAS);

endmodule
